demux_lane_collector: RTL and testbench

- Downstream consumer of the 1-to-4 bit demultiplexer.
- Takes the four demultiplexed serial lanes plus the select pair and a bit strobe, and assembles a WIDTH-bit word per lane.
- Buffers one complete word per lane and hands words out on a single valid/ready port, arbitrated round-robin and tagged with the lane index.

---
 rtl/demux_lane_collector_pkg.sv | 37 +++
 rtl/demux_lane_rr_arbiter.sv | 38 +++
 rtl/demux_lane_collector.sv | 181 ++++++++++++++++++
 tb/tb_demux_lane_collector.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_lane_collector_pkg.sv
// -----------------------------------------------------------------------------
// demux_lane_collector_pkg
//
// Shared definitions for the demux lane collector and anything else that must
// agree with it on lane numbering (e.g. the 1-to-4 demux bench):
//   NUM_LANES     number of demultiplexed lanes
//   LANE_IDX_W    width of a lane index
//   MAX_WIDTH     widest supported assembled word
//   MAX_CNT_W     bit-counter width sized for MAX_WIDTH
//   lane_idx_t    lane index type
//   lane_state_t  per-lane assembly state {shreg, cnt, hold, hold_valid}
//   sel_to_idx()  {sel_0, sel_1} -> lane index mapping
// -----------------------------------------------------------------------------
package demux_lane_collector_pkg;

    localparam int unsigned NUM_LANES  = 4;
    localparam int unsigned LANE_IDX_W = 2;
    localparam int unsigned MAX_WIDTH  = 32;
    localparam int unsigned MAX_CNT_W  = 5;

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    // Sized for the widest word; a collector built with a narrower WIDTH keeps
    // the unused upper bits at zero.
    typedef struct packed {
        logic [MAX_WIDTH-1:0] shreg;
        logic [MAX_CNT_W-1:0] cnt;
        logic [MAX_WIDTH-1:0] hold;
        logic                 hold_valid;
    } lane_state_t;

    // sel_0 is the index MSB, sel_1 the LSB.
    function automatic lane_idx_t sel_to_idx(input logic sel_0, input logic sel_1);
        return {sel_0, sel_1};
    endfunction

endpackage

// File: rtl/demux_lane_rr_arbiter.sv
// -----------------------------------------------------------------------------
// demux_lane_rr_arbiter
//
// Combinational round-robin picker over the four lane hold registers. Grants
// the first requesting lane found searching upward from pointer, wrapping
// 3 -> 0. The pointer register lives in the parent.
//
// Ports:
//   request      in   per-lane request (hold_valid)
//   pointer      in   lane to search from first
//   grant        out  granted lane index (pointer when nothing requests)
//   grant_valid  out  at least one lane is requesting
// -----------------------------------------------------------------------------
module demux_lane_rr_arbiter
    import demux_lane_collector_pkg::*;
(
    input  logic [NUM_LANES-1:0] request,
    input  lane_idx_t            pointer,
    output lane_idx_t            grant,
    output logic                 grant_valid
);

    always_comb begin
        grant       = pointer;
        grant_valid = 1'b0;
        // Walk from the farthest offset back to the pointer so the closest
        // requester is the last one written and therefore wins.
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            lane_idx_t idx;
            idx = pointer + LANE_IDX_W'(i);
            if (request[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_lane_collector.sv
// -----------------------------------------------------------------------------
// demux_lane_collector
//
// Downstream consumer of the 1-to-4 bit demultiplexer. Deserialises the bit
// on the selected lane into a per-lane WIDTH-bit word, buffers one finished
// word per lane and hands words out on a single valid/ready port, arbitrated
// round-robin and tagged with the source lane.
//
// Parameters:
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1: first received bit ends up in the word MSB; 0: in the LSB
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   bit_valid            a bit is present on the selected lane this cycle
//   sel_0, sel_1         lane index {sel_0, sel_1}
//   lane_0 .. lane_3     demux outputs; only the selected one is sampled
//   flush                drop all partially assembled words
//   ovf_clear            clear sticky overflow flags
//   out_data, out_lane   delivered word and its lane
//   out_valid, out_ready output handshake
//   overflow             per-lane sticky overflow (word dropped)
// -----------------------------------------------------------------------------
module demux_lane_collector
    import demux_lane_collector_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_valid,
    input  logic                 sel_0,
    input  logic                 sel_1,
    input  logic                 lane_0,
    input  logic                 lane_1,
    input  logic                 lane_2,
    input  logic                 lane_3,
    input  logic                 flush,
    input  logic                 ovf_clear,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           out_lane,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_LANES-1:0] overflow
);

    localparam logic [MAX_WIDTH-1:0] WORD_MASK = MAX_WIDTH'((64'd1 << WIDTH) - 64'd1);
    localparam logic [MAX_CNT_W-1:0] LAST_CNT  = MAX_CNT_W'(WIDTH - 1);

    lane_state_t          lane_q [NUM_LANES];
    lane_state_t          lane_d [NUM_LANES];
    lane_idx_t            ptr_q, ptr_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    lane_idx_t            out_lane_q, out_lane_d;
    logic                 out_valid_q, out_valid_d;
    logic [NUM_LANES-1:0] overflow_q, overflow_d;

    logic [NUM_LANES-1:0] hold_req;
    lane_idx_t            grant_idx;
    logic                 grant_valid;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            hold_req[i] = lane_q[i].hold_valid;
        end
    end

    demux_lane_rr_arbiter u_arbiter (
        .request     (hold_req),
        .pointer     (ptr_q),
        .grant       (grant_idx),
        .grant_valid (grant_valid)
    );

    lane_idx_t            cur_idx;
    logic                 cur_bit;
    logic                 load_ok;
    logic [NUM_LANES-1:0] xfer;
    logic [NUM_LANES-1:0] ovf_set;
    logic [MAX_WIDTH-1:0] new_word;

    always_comb begin
        cur_idx = sel_to_idx(sel_0, sel_1);
        unique case (cur_idx)
            2'd0:    cur_bit = lane_0;
            2'd1:    cur_bit = lane_1;
            2'd2:    cur_bit = lane_2;
            default: cur_bit = lane_3;
        endcase

        load_ok = !out_valid_q || out_ready;

        // Lane whose hold register moves into the output stage on this edge.
        xfer = '0;
        if (load_ok && grant_valid) begin
            xfer[grant_idx] = 1'b1;
        end

        for (int i = 0; i < NUM_LANES; i++) begin
            lane_d[i] = lane_q[i];
            if (flush) begin
                lane_d[i].shreg = '0;
                lane_d[i].cnt   = '0;
            end
            if (xfer[i]) begin
                lane_d[i].hold_valid = 1'b0;
            end
        end

        if (MSB_FIRST) begin
            new_word = ((lane_q[cur_idx].shreg << 1) | MAX_WIDTH'(cur_bit)) & WORD_MASK;
        end else begin
            new_word = (lane_q[cur_idx].shreg >> 1) | (MAX_WIDTH'(cur_bit) << (WIDTH - 1));
        end

        ovf_set = '0;
        // flush takes priority over a coincident bit.
        if (bit_valid && !flush) begin
            lane_d[cur_idx].shreg = new_word;
            if (lane_q[cur_idx].cnt == LAST_CNT) begin
                lane_d[cur_idx].cnt = '0;
                // A full hold slot is only reusable if it drains this edge.
                if (!lane_q[cur_idx].hold_valid || xfer[cur_idx]) begin
                    lane_d[cur_idx].hold       = new_word;
                    lane_d[cur_idx].hold_valid = 1'b1;
                end else begin
                    ovf_set[cur_idx] = 1'b1;
                end
            end else begin
                lane_d[cur_idx].cnt = lane_q[cur_idx].cnt + MAX_CNT_W'(1);
            end
        end

        // Set wins over a simultaneous clear.
        overflow_d = (ovf_clear ? '0 : overflow_q) | ovf_set;

        out_data_d  = out_data_q;
        out_lane_d  = out_lane_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_ok) begin
            if (grant_valid) begin
                out_data_d  = WIDTH'(lane_q[grant_idx].hold);
                out_lane_d  = grant_idx;
                out_valid_d = 1'b1;
                ptr_d       = grant_idx + LANE_IDX_W'(1);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_q[i] <= '0;
            end
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_lane_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_q[i] <= lane_d[i];
            end
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_lane_q  <= out_lane_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_lane  = out_lane_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_demux_lane_collector.sv
module tb_demux_lane_collector;

    logic clk = 1'b0;
    logic rst_n;
    logic bit_valid, sel_0, sel_1;
    logic lane_0, lane_1, lane_2, lane_3;
    logic flush, ovf_clear, out_ready;

    logic [7:0] m_data, l_data;
    logic [1:0] m_lane, l_lane;
    logic       m_valid, l_valid;
    logic [3:0] m_ovf, l_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_lane_collector #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .sel_0(sel_0), .sel_1(sel_1),
        .lane_0(lane_0), .lane_1(lane_1), .lane_2(lane_2), .lane_3(lane_3),
        .flush(flush), .ovf_clear(ovf_clear), .out_data(m_data), .out_lane(m_lane),
        .out_valid(m_valid), .out_ready(out_ready), .overflow(m_ovf)
    );

    demux_lane_collector #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .sel_0(sel_0), .sel_1(sel_1),
        .lane_0(lane_0), .lane_1(lane_1), .lane_2(lane_2), .lane_3(lane_3),
        .flush(flush), .ovf_clear(ovf_clear), .out_data(l_data), .out_lane(l_lane),
        .out_valid(l_valid), .out_ready(out_ready), .overflow(l_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Selected lane carries b, the others carry ~b so any cross-lane sampling shows up.
    task automatic drive_bit(input int lane, input logic b);
        logic [1:0] l;
        l = 2'(lane);
        sel_0 = l[1];
        sel_1 = l[0];
        lane_0 = ~b; lane_1 = ~b; lane_2 = ~b; lane_3 = ~b;
        case (l)
            2'd0: lane_0 = b;
            2'd1: lane_1 = b;
            2'd2: lane_2 = b;
            default: lane_3 = b;
        endcase
        bit_valid = 1'b1;
    endtask

    // Sends w[7] first. Starts and ends at a falling edge.
    task automatic send_word(input int lane, input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            drive_bit(lane, w[i]);
            @(negedge clk);
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; bit_valid = 1'b0; sel_0 = 1'b0; sel_1 = 1'b0;
        lane_0 = 1'b0; lane_1 = 1'b0; lane_2 = 1'b0; lane_3 = 1'b0;
        flush = 1'b0; ovf_clear = 1'b0; out_ready = 1'b1;

        #3;
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_lane", 32'(m_lane), 0);
        chk("rst_ovf", 32'(m_ovf), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // MSB-first A5 on lane 1, delivered two edges after the last bit.
        send_word(1, 8'hA5);
        chk("t1_early", 32'(m_valid), 0);
        @(negedge clk);
        chk("t1_valid", 32'(m_valid), 1);
        chk("t1_data", 32'(m_data), 32'hA5);
        chk("t1_lane", 32'(m_lane), 1);
        @(negedge clk);
        chk("t1_one_cycle", 32'(m_valid), 0);

        // Lane 3, both bit orders.
        send_word(3, 8'hA5);
        @(negedge clk);
        chk("t2_lsb_data", 32'(l_data), 32'hA5);
        chk("t2_lsb_lane", 32'(l_lane), 3);
        @(negedge clk);
        send_word(3, 8'hC0);
        @(negedge clk);
        chk("t2_lsb_c0", 32'(l_data), 32'h03);
        chk("t2_msb_c0", 32'(m_data), 32'hC0);
        chk("t2_valid", 32'(l_valid), 1);
        @(negedge clk);

        // Lanes 0, 2, 3 with the output stalled; lane 0 lands in the output stage.
        out_ready = 1'b0;
        send_word(0, 8'h11);
        send_word(2, 8'h22);
        send_word(3, 8'h33);
        chk("t3_first_lane", 32'(m_lane), 0);
        chk("t3_first_data", 32'(m_data), 32'h11);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_second_lane", 32'(m_lane), 2);
        chk("t3_second_data", 32'(m_data), 32'h22);
        @(negedge clk);
        chk("t3_third_lane", 32'(m_lane), 3);
        chk("t3_third_data", 32'(m_data), 32'h33);
        @(negedge clk);
        chk("t3_drained", 32'(m_valid), 0);

        // Pointer is 0 after the lane 3 grant: lane 0 goes before lane 3.
        out_ready = 1'b0;
        send_word(3, 8'h44);
        send_word(0, 8'h55);
        send_word(3, 8'h66);
        chk("t3b_head_lane", 32'(m_lane), 3);
        chk("t3b_head_data", 32'(m_data), 32'h44);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3b_lane0", 32'(m_lane), 0);
        chk("t3b_data0", 32'(m_data), 32'h55);
        @(negedge clk);
        chk("t3b_lane3", 32'(m_lane), 3);
        chk("t3b_data3", 32'(m_data), 32'h66);
        @(negedge clk);
        chk("t3b_drained", 32'(m_valid), 0);

        // Overflow on lane 2 with output stage and hold both occupied.
        out_ready = 1'b0;
        send_word(1, 8'h12);
        send_word(2, 8'h77);
        chk("t4_no_ovf_yet", 32'(m_ovf), 0);
        send_word(2, 8'h88);
        chk("t4_ovf_m", 32'(m_ovf), 32'h4);
        chk("t4_ovf_l", 32'(l_ovf), 32'h4);
        chk("t4_head_data", 32'(m_data), 32'h12);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_kept_lane", 32'(m_lane), 2);
        chk("t4_kept_data", 32'(m_data), 32'h77);
        @(negedge clk);
        chk("t4_dropped", 32'(m_valid), 0);
        chk("t4_ovf_sticky", 32'(m_ovf), 32'h4);
        ovf_clear = 1'b1;
        @(negedge clk);
        ovf_clear = 1'b0;
        chk("t4_ovf_cleared", 32'(m_ovf), 0);

        // Five partial bits, then flush with a coincident 0 bit, then FF.
        drive_bit(0, 1'b1); @(negedge clk);
        drive_bit(0, 1'b0); @(negedge clk);
        drive_bit(0, 1'b1); @(negedge clk);
        drive_bit(0, 1'b0); @(negedge clk);
        drive_bit(0, 1'b1); @(negedge clk);
        flush = 1'b1;
        drive_bit(0, 1'b0); @(negedge clk);
        flush = 1'b0;
        send_word(0, 8'hFF);
        chk("t5_no_early", 32'(m_valid), 0);
        @(negedge clk);
        chk("t5_valid", 32'(m_valid), 1);
        chk("t5_data", 32'(m_data), 32'hFF);
        chk("t5_lane", 32'(m_lane), 0);
        @(negedge clk);

        // Async reset mid-word with a word parked in the output stage.
        out_ready = 1'b0;
        send_word(1, 8'h3C);
        @(negedge clk);
        chk("t6_parked", 32'(m_valid), 1);
        drive_bit(2, 1'b1); @(negedge clk);
        drive_bit(2, 1'b1); @(negedge clk);
        drive_bit(2, 1'b1); @(negedge clk);
        drive_bit(2, 1'b1); @(negedge clk);
        bit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(m_valid), 0);
        chk("t6_rst_data", 32'(m_data), 0);
        chk("t6_rst_lane", 32'(m_lane), 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_word(1, 8'h96);
        @(negedge clk);
        chk("t6_after_valid", 32'(m_valid), 1);
        chk("t6_after_data", 32'(m_data), 32'h96);
        chk("t6_after_lane", 32'(m_lane), 1);
        @(negedge clk);
        send_word(2, 8'h5A);
        chk("t6_lane2_early", 32'(m_valid), 0);
        @(negedge clk);
        chk("t6_lane2_data", 32'(m_data), 32'h5A);
        chk("t6_lane2_lane", 32'(m_lane), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
